// File: rtl/alu_pkg.sv
// Shared definitions for alu_muldiv_seq: MIPS funct codes, FSM state encoding
// and the decode helper that separates iterative ops from single-cycle ops.
package alu_pkg;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic logic is_muldiv(input logic [5:0] funct);
        logic res;
        case (funct)
            F_MULT, F_MULTU, F_DIV, F_DIVU: res = 1'b1;
            default:                        res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Issue/result bundle of alu_muldiv_seq; the pipeline drives the master side,
// the execute unit implements the slave side.
interface alu_muldiv_seq_if #(parameter int N = 32);
    logic         start_valid;
    logic         start_ready;
    logic [5:0]   opcode;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] out;
    logic         out_valid;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         div_by_zero;
    logic         ovf;

    modport master (
        output start_valid, opcode, A, B,
        input  start_ready, out, out_valid, hi, lo, div_by_zero, ovf
    );

    modport slave (
        input  start_valid, opcode, A, B,
        output start_ready, out, out_valid, hi, lo, div_by_zero, ovf
    );
endinterface

// File: rtl/muldiv_iter.sv
// Unsigned one-bit-per-cycle engine: shift-add multiply or restoring divide on
// operand magnitudes; o_done marks the step that completes the N-th iteration.
module muldiv_iter #(parameter int N = 32) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         is_div,
    input  logic [N-1:0] a_mag,
    input  logic [N-1:0] b_mag,
    input  logic         step_en,
    output logic [N-1:0] o_hi,
    output logic [N-1:0] o_lo,
    output logic         o_done
);
    localparam int CW = $clog2(N);

    logic [N-1:0]  r_hi, r_lo, r_b;
    logic          r_is_div;
    logic [CW-1:0] r_cnt;
    logic [N:0]    w_sum, w_shift, w_diff;
    logic [N-1:0]  w_hi_nxt, w_lo_nxt;

    // Next accumulator value for one multiply or divide iteration
    always_comb begin
        w_sum    = {1'b0, r_hi} + {1'b0, r_b};
        w_shift  = {r_hi, r_lo[N-1]};
        w_diff   = w_shift - {1'b0, r_b};
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_is_div) begin
            // bit N of the difference is the borrow: divisor did not fit
            if (w_diff[N]) begin
                w_hi_nxt = w_shift[N-1:0];
                w_lo_nxt = {r_lo[N-2:0], 1'b0};
            end else begin
                w_hi_nxt = w_diff[N-1:0];
                w_lo_nxt = {r_lo[N-2:0], 1'b1};
            end
        end else begin
            if (r_lo[0]) begin
                w_hi_nxt = w_sum[N:1];
                w_lo_nxt = {w_sum[0], r_lo[N-1:1]};
            end else begin
                w_hi_nxt = {1'b0, r_hi[N-1:1]};
                w_lo_nxt = {r_hi[0], r_lo[N-1:1]};
            end
        end
    end

    // Accumulator, operand and iteration-counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi     <= {N{1'b0}};
            r_lo     <= {N{1'b0}};
            r_b      <= {N{1'b0}};
            r_is_div <= 1'b0;
            r_cnt    <= {CW{1'b0}};
        end else if (load) begin
            r_hi     <= {N{1'b0}};
            r_lo     <= a_mag;
            r_b      <= b_mag;
            r_is_div <= is_div;
            r_cnt    <= {CW{1'b0}};
        end else if (step_en) begin
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_done = step_en && (r_cnt == CW'(N - 1));
endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MIPS execute ALU with iterative mult/div and HI/LO registers.
// Define ALU_OVF_EN to build the signed add/sub overflow flag.
module alu_muldiv_seq import alu_pkg::*; #(parameter int N = 32) (
    input logic         clk,
    input logic         rst,
    alu_muldiv_seq_if.slave bus
);
    localparam logic [N-1:0] ZERO = {N{1'b0}};
    localparam logic [N-1:0] ONES = {N{1'b1}};

    state_t       r_state;
    logic [N-1:0] r_out, r_hi, r_lo, r_a;
    logic         r_out_valid, r_dbz, r_is_div, r_neg_q, r_neg_r, r_b_zero;

    logic         w_accept, w_op_md, w_op_div, w_op_signed, w_a_neg, w_b_neg, w_b_zero, w_done;
    logic [N-1:0] w_a_mag, w_b_mag, w_sum, w_dif, w_alu_out;
    logic [N-1:0] w_it_hi, w_it_lo, w_q, w_r, w_res_hi, w_res_lo;
    logic [2*N-1:0] w_prod;

    assign w_accept = bus.start_valid && (r_state == S_IDLE);

    // Issue decode: operand signs and magnitudes for the iterative engine
    always_comb begin
        w_op_md     = is_muldiv(bus.opcode);
        w_op_div    = (bus.opcode == F_DIV) || (bus.opcode == F_DIVU);
        w_op_signed = (bus.opcode == F_MULT) || (bus.opcode == F_DIV);
        w_a_neg     = w_op_signed && bus.A[N-1];
        w_b_neg     = w_op_signed && bus.B[N-1];
        w_a_mag     = w_a_neg ? (ZERO - bus.A) : bus.A;
        w_b_mag     = w_b_neg ? (ZERO - bus.B) : bus.B;
        w_b_zero    = w_op_div && (bus.B == ZERO);
        w_sum       = bus.A + bus.B;
        w_dif       = bus.A - bus.B;
    end

    // Single-cycle result selection
    always_comb begin
        w_alu_out = ZERO;
        case (bus.opcode)
            F_ADD:   w_alu_out = w_sum;
            F_SUB:   w_alu_out = w_dif;
            F_AND:   w_alu_out = bus.A & bus.B;
            F_OR:    w_alu_out = bus.A | bus.B;
            F_XOR:   w_alu_out = bus.A ^ bus.B;
            F_NOR:   w_alu_out = ~(bus.A | bus.B);
            F_SLT:   w_alu_out = {{(N-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            F_SLTU:  w_alu_out = {{(N-1){1'b0}}, (bus.A < bus.B)};
            F_MFHI:  w_alu_out = r_hi;
            F_MFLO:  w_alu_out = r_lo;
            default: w_alu_out = ZERO;
        endcase
    end

    // Sign fix-up of the unsigned engine result; remainder follows the dividend
    always_comb begin
        w_prod = r_neg_q ? ({(2*N){1'b0}} - {w_it_hi, w_it_lo}) : {w_it_hi, w_it_lo};
        w_q    = r_neg_q ? (ZERO - w_it_lo) : w_it_lo;
        w_r    = r_neg_r ? (ZERO - w_it_hi) : w_it_hi;
        if (r_is_div && r_b_zero) begin
            w_res_hi = r_a;
            w_res_lo = ONES;
        end else if (r_is_div) begin
            w_res_hi = w_r;
            w_res_lo = w_q;
        end else begin
            w_res_hi = w_prod[2*N-1:N];
            w_res_lo = w_prod[N-1:0];
        end
    end

    muldiv_iter #(.N(N)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (w_accept && w_op_md),
        .is_div  (w_op_div),
        .a_mag   (w_a_mag),
        .b_mag   (w_b_mag),
        .step_en (r_state == S_CALC),
        .o_hi    (w_it_hi),
        .o_lo    (w_it_lo),
        .o_done  (w_done)
    );

    // Control FSM with registered result, HI/LO and sticky divide-by-zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out       <= ZERO;
            r_out_valid <= 1'b0;
            r_hi        <= ZERO;
            r_lo        <= ZERO;
            r_a         <= ZERO;
            r_dbz       <= 1'b0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_b_zero    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_op_md) begin
                        r_a      <= bus.A;
                        r_is_div <= w_op_div;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_b_zero <= w_b_zero;
                        if (w_op_div) begin
                            r_dbz <= 1'b0;
                        end
                        r_state  <= w_b_zero ? S_DONE : S_CALC;
                    end else if (w_accept) begin
                        r_out       <= w_alu_out;
                        r_out_valid <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (w_done) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_hi        <= w_res_hi;
                    r_lo        <= w_res_lo;
                    r_out       <= w_res_lo;
                    r_out_valid <= 1'b1;
                    if (r_is_div && r_b_zero) begin
                        r_dbz <= 1'b1;
                    end
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_OVF_EN
    logic w_ovf, r_ovf;

    // Signed overflow: operands agree in sign (add) or differ (sub) and result flips
    always_comb begin
        w_ovf = 1'b0;
        if (bus.opcode == F_ADD) begin
            w_ovf = (bus.A[N-1] == bus.B[N-1]) && (w_sum[N-1] != bus.A[N-1]);
        end else if (bus.opcode == F_SUB) begin
            w_ovf = (bus.A[N-1] != bus.B[N-1]) && (w_dif[N-1] != bus.A[N-1]);
        end else begin
            w_ovf = 1'b0;
        end
    end

    // Overflow flag registered alongside the single-cycle result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= w_ovf;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.start_ready = (r_state == S_IDLE);
    assign bus.out         = r_out;
    assign bus.out_valid   = r_out_valid;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomised and directed bench for alu_muldiv_seq against a plain-arithmetic
// model of HI/LO, results, sticky divide-by-zero, overflow and latency.
module tb_alu_muldiv_seq;
    localparam int N = 32;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_BAD   = 6'b000011;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    logic [31:0] m_hi, m_lo;
    logic        m_dbz;

    alu_muldiv_seq_if #(.N(N)) bif ();

    alu_muldiv_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour; e_lat counts clock edges including the accept edge
    task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] e_out, output logic e_ovf, output int e_lat);
        longint sa, sb, s;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        e_ovf = 1'b0;
        e_lat = 1;
        e_out = 32'h0;
        case (op)
            F_ADD:  begin e_out = a + b; s = sa + sb; e_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            F_SUB:  begin e_out = a - b; s = sa - sb; e_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            F_AND:  e_out = a & b;
            F_OR:   e_out = a | b;
            F_XOR:  e_out = a ^ b;
            F_NOR:  e_out = ~(a | b);
            F_SLT:  e_out = (sa < sb) ? 32'd1 : 32'd0;
            F_SLTU: e_out = (a < b) ? 32'd1 : 32'd0;
            F_MFHI: e_out = m_hi;
            F_MFLO: e_out = m_lo;
            F_MULT, F_MULTU: begin
                if (op == F_MULT) p = sa * sb;
                else              p = {32'h0, a} * {32'h0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
                e_out = m_lo;
                e_lat = N + 2;
            end
            F_DIV, F_DIVU: begin
                if (b == 32'h0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF; m_dbz = 1'b1; e_lat = 2;
                end else begin
                    m_dbz = 1'b0;
                    e_lat = N + 2;
                    if (op == F_DIVU) begin
                        m_lo = a / b; m_hi = a % b;
                    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000; m_hi = 32'h0;
                    end else begin
                        m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
                    end
                end
                e_out = m_lo;
            end
            default: e_out = 32'h0;
        endcase
`ifndef ALU_OVF_EN
        e_ovf = 1'b0;
`endif
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
        logic [31:0] e_out;
        logic        e_ovf;
        int          e_lat, w, lat, lows;
        w = 0;
        @(negedge clk);
        while (!bif.start_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) check_eq("ready_timeout", 64'd0, 64'd1);
        bif.start_valid = 1'b1;
        bif.opcode = op;
        bif.A = a;
        bif.B = b;
        model(op, a, b, e_out, e_ovf, e_lat);
        @(posedge clk);
        #1;
        bif.start_valid = 1'b0;
        bif.A = $urandom;
        bif.B = $urandom;
        lat = 1;
        lows = 0;
        while (!bif.out_valid && lat < 100) begin
            if (!bif.start_ready) lows++;
            if (noise) begin
                bif.start_valid = 1'b1;
                bif.opcode = F_ADD;
                bif.A = $urandom;
                bif.B = $urandom;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bif.start_valid = 1'b0;
        check_eq("latency", 64'(lat), 64'(e_lat));
        check_eq("busy_cycles", 64'(lows), 64'(e_lat - 1));
        check_eq("out", 64'(bif.out), 64'(e_out));
        check_eq("hi", 64'(bif.hi), 64'(m_hi));
        check_eq("lo", 64'(bif.lo), 64'(m_lo));
        check_eq("div_by_zero", 64'(bif.div_by_zero), 64'(m_dbz));
        check_eq("ovf", 64'(bif.ovf), 64'(e_ovf));
        @(posedge clk);
        #1;
        check_eq("out_valid_pulse", 64'(bif.out_valid), 64'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'($urandom_range(0, 15));
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] ops [15] = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU,
                                 F_MFHI, F_MFLO, F_MULT, F_MULTU, F_DIV, F_DIVU, F_BAD};
        rst = 1'b1;
        bif.start_valid = 1'b0;
        bif.opcode = 6'h0;
        bif.A = 32'h0;
        bif.B = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        m_dbz = 1'b0;
        #12;
        check_eq("rst_out", 64'(bif.out), 64'd0);
        check_eq("rst_out_valid", 64'(bif.out_valid), 64'd0);
        check_eq("rst_hi", 64'(bif.hi), 64'd0);
        check_eq("rst_lo", 64'(bif.lo), 64'd0);
        check_eq("rst_dbz", 64'(bif.div_by_zero), 64'd0);
        check_eq("rst_ovf", 64'(bif.ovf), 64'd0);
        check_eq("rst_ready", 64'(bif.start_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        issue(F_ADD, 32'd10, 32'd5, 1'b0);
        issue(F_AND, 32'd10, 32'd5, 1'b0);
        issue(F_OR,  32'd10, 32'd5, 1'b0);
        issue(F_SLT, 32'd10, 32'd5, 1'b0);
        issue(F_SUB, 32'd10, 32'd5, 1'b0);
        issue(F_SLT, 32'd5, 32'd10, 1'b0);
        issue(F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
        issue(F_MFHI, 32'd0, 32'd0, 1'b0);
        issue(F_MFLO, 32'd0, 32'd0, 1'b0);
        issue(F_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        issue(F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(F_DIVU, 32'd7, 32'd2, 1'b0);
        issue(F_DIVU, 32'd9, 32'd0, 1'b0);
        issue(F_ADD, 32'd1, 32'd1, 1'b0);
        issue(F_DIVU, 32'd8, 32'd4, 1'b0);
        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(F_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
        issue(F_SUB, 32'h8000_0000, 32'd1, 1'b0);
        issue(F_BAD, 32'd3, 32'd4, 1'b0);

        // Abort a multiply partway through CALC with an asynchronous reset
        @(negedge clk);
        bif.start_valid = 1'b1;
        bif.opcode = F_MULT;
        bif.A = 32'd123;
        bif.B = 32'd456;
        @(posedge clk);
        #1;
        bif.start_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        m_hi = 32'h0;
        m_lo = 32'h0;
        m_dbz = 1'b0;
        check_eq("abort_out", 64'(bif.out), 64'd0);
        check_eq("abort_hi", 64'(bif.hi), 64'd0);
        check_eq("abort_lo", 64'(bif.lo), 64'd0);
        check_eq("abort_out_valid", 64'(bif.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort_ready", 64'(bif.start_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_no_result", 64'(bif.out_valid), 64'd0);
        check_eq("abort_hi_held", 64'(bif.hi), 64'd0);

        for (int i = 0; i < 60; i++) begin
            issue(ops[$urandom_range(0, 14)], rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Parametrised, multi-cycle successor to the combinational 32-bit ALU. Keeps the MIPS R-type funct encoding.
- Adds an iterative multiply/divide engine with architectural HI/LO registers and mfhi/mflo, behind a valid/ready issue handshake.
- Sits in the execute stage of the MIPS datapath. The pipeline stalls while start_ready is low.

Parameters:
N, 32, operand/result width in bits (N >= 4, even)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start_valid  in  1  operation request
start_ready  out  1  block can accept a request (high only in IDLE)
opcode  in  6  MIPS funct code
A  in  N  operand rs
B  in  N  operand rt
out  out  N  registered result
out_valid  out  1  one-cycle pulse, out holds new result
hi  out  N  HI register
lo  out  N  LO register
div_by_zero  out  1  sticky until next accepted div/divu
ovf  out  1  signed overflow of add/sub (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state=IDLE, out=0, out_valid=0, hi=0, lo=0, div_by_zero=0, ovf=0. Asserting reset mid-operation aborts it. HI/LO are cleared, not partially written.
- Accept when start_valid && start_ready on a rising edge. Inputs are sampled only at accept.
- FSM states:
  - IDLE: start_ready=1.
  - CALC: iterative, counter 0..N-1.
  - DONE: sign fix-up, write HI/LO.
- Single-cycle ops (IDLE->IDLE): out and out_valid are registered at the accept edge, so visible 1 cycle after accept.
  - add 100000 / sub 100010: A±B mod 2^N, no trap.
  - and 100100, or 100101, xor 100110, nor 100111.
  - slt 101010: signed compare. sltu 101011: unsigned compare. Result is 0 or 1, zero-extended.
  - mfhi 010000 -> out=hi. mflo 010010 -> out=lo.
  - Unknown funct: out=0, out_valid pulses.
- Multi-cycle ops: mult 011000, multu 011001, div 011010, divu 011011.
  - Accept: IDLE->CALC. For signed ops, latch operand magnitudes and the result signs.
  - CALC: shift-add multiply, or restoring divide, one bit per cycle for N cycles. Then ->DONE.
  - DONE: negate results per latched signs. Multiply: {hi,lo}=2N-bit product. Divide: lo=quotient, hi=remainder (remainder takes the dividend's sign). out_valid pulses with out=lo. Then ->IDLE.
  - Latency: out_valid and updated hi/lo appear exactly N+2 edges after the accept edge. start_ready is low for N+1 cycles.
  - HI/LO change only in DONE.
- Divide by zero (B=0): skips CALC (IDLE->DONE). Result hi=A, lo=all-ones, div_by_zero=1. Latency 2 edges.
- Signed most-negative / -1: lo=most-negative, hi=0, div_by_zero=0.
- start_valid while busy is ignored (no queue). out_valid has no backpressure.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined: ovf is registered alongside out for add/sub. ovf=1 when the signed result's sign differs from the mathematically correct sign. It is 0 for every other op and is valid only with out_valid.
- Undefined: the overflow logic is not synthesised and ovf is tied to 0.

Decomposition:
- Package alu_pkg:
  - localparam funct codes (F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU, F_MFHI, F_MFLO, F_MULT, F_MULTU, F_DIV, F_DIVU).
  - State enum (S_IDLE, S_CALC, S_DONE).
  - Helper function is_muldiv(funct).
- Sub-module muldiv_iter, parametrised by N:
  - Ports: clk, rst, load, is_div, a_mag, b_mag, step_en.
  - Outputs: N-bit partial hi/lo accumulators and a done flag.
- The top level holds the FSM, the single-cycle datapath, sign fix-up and the HI/LO registers.

Test Plan:
- Single-cycle ops, A=10, B=5: add->15, and->0, or->15, slt->0, sub->5. Each out_valid arrives 1 cycle after accept. A=5, B=10, slt -> 1.
- mult A=-3 (0xFFFFFFFD), B=7: after 34 edges hi=0xFFFFFFFF, lo=0xFFFFFFEB. start_ready is low for 33 cycles. Then mfhi->0xFFFFFFFF and mflo->0xFFFFFFEB.
- multu A=0xFFFFFFFF, B=2 -> hi=1, lo=0xFFFFFFFE. div A=-7, B=2 -> lo=-3, hi=-1. divu A=7, B=2 -> lo=3, hi=1.
- divu A=9, B=0 -> lo=0xFFFFFFFF, hi=9, div_by_zero=1, 2-edge latency. A later divu A=8, B=4 clears div_by_zero.
- Assert rst at CALC cycle 10 of a mult: outputs clear immediately, start_ready=1 on release, hi=lo=0.
- With ALU_OVF_EN: add A=0x7FFFFFFF, B=1 -> out=0x80000000, ovf=1. sub 0x80000000-1 -> ovf=1. Without the macro, ovf stays 0.
